// File: rtl/proc_sequencer.sv
// proc_sequencer: single-issue step sequencer for a tiny ROM/RAM/ALU datapath.
//
// A load pulse writes an operand word into data RAM address 0. A step pulse
// fetches the opcode at PC from program ROM while the operand is read from RAM
// address 0. The external ALU then sees opcode and operand, and its result is
// latched, flagged with result_valid and written back (low 8 bits) to RAM
// address 1. PC then advances, wrapping after LAST_PC.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   step, load         one-cycle request pulses, honoured only when idle
//   sw_data[7:0]       operand word {b, a} written on load
//   prom_data[3:0]     program ROM read data (1-cycle latency)
//   dram_q[7:0]        data RAM read data (consumed by the ALU, not here)
//   ula_out[8:0]       combinational ALU result
//   ula_sinal          combinational ALU sign flag
//   prom_addr[2:0]     program ROM address
//   dram_addr          data RAM address
//   dram_we            data RAM write enable
//   dram_wdata[7:0]    data RAM write data
//   opcode[3:0]        latched opcode driving the ALU
//   result[8:0]        latched ALU result
//   result_sign        latched ALU sign
//   result_valid       one-cycle pulse marking a new result
//   busy               high whenever the sequencer is not idle
//   pc[2:0]            program counter
module proc_sequencer #(
   parameter int LAST_PC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       load,
   input  logic [7:0] sw_data,
   input  logic [3:0] prom_data,
   input  logic [7:0] dram_q,
   input  logic [8:0] ula_out,
   input  logic       ula_sinal,
   output logic [2:0] prom_addr,
   output logic       dram_addr,
   output logic       dram_we,
   output logic [7:0] dram_wdata,
   output logic [3:0] opcode,
   output logic [8:0] result,
   output logic       result_sign,
   output logic       result_valid,
   output logic       busy,
   output logic [2:0] pc
);

   typedef enum logic [2:0] {IDLE, LOAD, FETCH, EXEC, WB} state_t;

   localparam logic [2:0] LAST = LAST_PC[2:0];

   state_t     state, state_d;
   logic [2:0] pc_d, prom_addr_d;
   logic       dram_addr_d, dram_we_d, result_sign_d, result_valid_d, busy_d;
   logic [7:0] dram_wdata_d;
   logic [3:0] opcode_d;
   logic [8:0] result_d;

   // The operand path runs RAM -> ALU directly; the sequencer only times it.
   logic unused_dram_q;
   assign unused_dram_q = ^dram_q;

   always_comb begin
      state_d        = state;
      pc_d           = pc;
      prom_addr_d    = prom_addr;
      dram_addr_d    = dram_addr;
      dram_we_d      = 1'b0;
      dram_wdata_d   = dram_wdata;
      opcode_d       = opcode;
      result_d       = result;
      result_sign_d  = result_sign;
      result_valid_d = 1'b0;
      case (state)
         IDLE: begin
            // load wins over a simultaneous step; the step is dropped
            if (load) begin
               state_d      = LOAD;
               dram_we_d    = 1'b1;
               dram_addr_d  = 1'b0;
               dram_wdata_d = sw_data;
            end else if (step) begin
               state_d     = FETCH;
               prom_addr_d = pc;
               dram_addr_d = 1'b0;
            end
         end
         LOAD:  state_d = IDLE;
         // ROM and RAM both have one cycle of read latency; FETCH absorbs it
         FETCH: state_d = EXEC;
         EXEC: begin
            opcode_d = prom_data;
            state_d  = WB;
         end
         WB: begin
            // ALU output is valid this cycle; results appear registered next cycle
            result_d       = ula_out;
            result_sign_d  = ula_sinal;
            result_valid_d = 1'b1;
            dram_we_d      = 1'b1;
            dram_addr_d    = 1'b1;
            dram_wdata_d   = ula_out[7:0];
            pc_d           = (pc == LAST) ? 3'd0 : pc + 3'd1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         pc           <= 3'd0;
         prom_addr    <= 3'd0;
         dram_addr    <= 1'b0;
         dram_we      <= 1'b0;
         dram_wdata   <= 8'd0;
         opcode       <= 4'd0;
         result       <= 9'd0;
         result_sign  <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_d;
         pc           <= pc_d;
         prom_addr    <= prom_addr_d;
         dram_addr    <= dram_addr_d;
         dram_we      <= dram_we_d;
         dram_wdata   <= dram_wdata_d;
         opcode       <= opcode_d;
         result       <= result_d;
         result_sign  <= result_sign_d;
         result_valid <= result_valid_d;
         busy         <= busy_d;
      end
   end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with behavioural ROM, RAM and ALU models.
module tb_proc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       step = 1'b0, load = 1'b0;
   logic [7:0] sw_data = 8'h00;
   logic [3:0] prom_data = 4'h0;
   logic [7:0] dram_q = 8'h00;
   logic [8:0] ula_out;
   logic       ula_sinal;
   logic [2:0] prom_addr, pc;
   logic       dram_addr, dram_we, result_sign, result_valid, busy;
   logic [7:0] dram_wdata;
   logic [3:0] opcode;
   logic [8:0] result;

   int total = 0, bad = 0;

   logic [3:0] rom [8];
   logic [7:0] ram [2];

   always #5 clk = ~clk;

   proc_sequencer dut (
      .clk(clk), .rst(rst), .step(step), .load(load), .sw_data(sw_data),
      .prom_data(prom_data), .dram_q(dram_q), .ula_out(ula_out),
      .ula_sinal(ula_sinal), .prom_addr(prom_addr), .dram_addr(dram_addr),
      .dram_we(dram_we), .dram_wdata(dram_wdata), .opcode(opcode),
      .result(result), .result_sign(result_sign),
      .result_valid(result_valid), .busy(busy), .pc(pc)
   );

   // ROM and RAM with one cycle of read latency
   always @(posedge clk) begin
      prom_data <= rom[prom_addr];
      dram_q    <= ram[dram_addr];
      if (dram_we) ram[dram_addr] <= dram_wdata;
   end

   // ALU: op1 a+b, op2 a-b (sign = bit 8), anything else passes the operand
   always_comb begin
      logic [8:0] a, b;
      a = {5'd0, dram_q[3:0]};
      b = {5'd0, dram_q[7:4]};
      ula_out   = {1'b0, dram_q};
      ula_sinal = 1'b0;
      case (opcode)
         4'h1: ula_out = a + b;
         4'h2: begin ula_out = a - b; ula_sinal = ula_out[8]; end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " pc"}, pc, 0);
      chk({tag, " prom_addr"}, prom_addr, 0);
      chk({tag, " dram_addr"}, dram_addr, 0);
      chk({tag, " dram_we"}, dram_we, 0);
      chk({tag, " dram_wdata"}, dram_wdata, 0);
      chk({tag, " opcode"}, opcode, 0);
      chk({tag, " result"}, result, 0);
      chk({tag, " result_sign"}, result_sign, 0);
      chk({tag, " result_valid"}, result_valid, 0);
   endtask

   // Step issued in cycle n; result_valid must appear only in cycle n+4,
   // together with the write-back to address 1.
   task automatic run_step(input string tag, input logic [3:0] exp_op,
                           input logic [8:0] exp_res, input logic exp_sign,
                           input logic [2:0] exp_pc);
      int hits = 0, at = 0;
      logic we = 0, wa = 0;
      logic [7:0] wd = 0;
      step = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) step = 1'b0;
         if (result_valid) begin
            hits++; at = k; we = dram_we; wa = dram_addr; wd = dram_wdata;
         end
      end
      chk({tag, " rv_count"}, hits, 1);
      chk({tag, " rv_cycle"}, at, 4);
      chk({tag, " wb_we"}, we, 1);
      chk({tag, " wb_addr"}, wa, 1);
      chk({tag, " wb_data"}, wd, exp_res[7:0]);
      chk({tag, " opcode"}, opcode, exp_op);
      chk({tag, " result"}, result, exp_res);
      chk({tag, " sign"}, result_sign, exp_sign);
      chk({tag, " pc"}, pc, exp_pc);
      chk({tag, " ram1"}, ram[1], exp_res[7:0]);
   endtask

   task automatic run_load(input string tag, input logic [7:0] d, input logic with_step);
      load = 1'b1; sw_data = d; step = with_step;
      @(negedge clk);
      load = 1'b0; step = 1'b0;
      chk({tag, " we"}, dram_we, 1);
      chk({tag, " addr"}, dram_addr, 0);
      chk({tag, " wdata"}, dram_wdata, d);
      chk({tag, " busy"}, busy, 1);
      @(negedge clk);
      chk({tag, " we_off"}, dram_we, 0);
      chk({tag, " busy_off"}, busy, 0);
      chk({tag, " ram0"}, ram[0], d);
   endtask

   initial begin
      int rv;
      logic [2:0] pc0;
      rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = 4'h0; rom[3] = 4'h3;
      rom[4] = 4'h1; rom[5] = 4'h0; rom[6] = 4'h0; rom[7] = 4'h0;
      ram[0] = 8'h00; ram[1] = 8'h00;

      #12;
      chk_reset("rst");
      @(negedge clk); rst = 1'b1;
      @(negedge clk);

      run_load("load35", 8'h35, 1'b0);

      // a=5 b=3: op1 -> 8, op2 -> 2, op0/op3 pass 0x35
      run_step("s1", 4'h1, 9'h008, 1'b0, 3'd1);
      run_step("s2", 4'h2, 9'h002, 1'b0, 3'd2);
      run_step("s3", 4'h0, 9'h035, 1'b0, 3'd3);
      run_step("s4", 4'h3, 9'h035, 1'b0, 3'd4);
      run_step("s5", 4'h1, 9'h008, 1'b0, 3'd0);
      run_step("s6", 4'h1, 9'h008, 1'b0, 3'd1);

      // load and step together: only the load happens
      pc0 = pc;
      run_load("ldstep", 8'h53, 1'b1);
      rv = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (result_valid || busy) rv++;
      end
      chk("ldstep no_exec", rv, 0);
      chk("ldstep pc", pc, pc0);

      // a=3 b=5: op2 -> -2, negative
      run_step("neg", 4'h2, 9'h1FE, 1'b1, 3'd2);

      // extra step in FETCH, then reset during EXEC
      step = 1'b1;
      @(negedge clk);              // FETCH
      chk("abort busy_fetch", busy, 1);
      @(negedge clk);              // EXEC; the step held through FETCH
      step = 1'b0;
      chk("abort busy_exec", busy, 1);
      rst = 1'b0;
      #1;
      chk_reset("abort");
      @(negedge clk);
      rst = 1'b1;
      rv = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (result_valid || dram_we || busy) rv++;
      end
      chk("abort quiet", rv, 0);
      chk("abort pc", pc, 0);
      chk("abort ram0", ram[0], 8'h53);

      // first step after reset runs ROM[0]: 3+5 = 8
      run_step("post", 4'h1, 9'h008, 1'b0, 3'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 The module SHALL have parameter LAST_PC, default 4, giving the highest program address executed before PC wraps to 0 (legal range 0..7).
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port step, input, 1 bit: one-cycle pulse (debounced upstream) requesting execution of the instruction at PC.
REQ-005 The module SHALL have port load, input, 1 bit: one-cycle pulse requesting an operand write into data RAM.
REQ-006 The module SHALL have port sw_data, input, 8 bits: operand word {b[3:0], a[3:0]} to write on load.
REQ-007 The module SHALL have port prom_data, input, 4 bits: program ROM read data (1-cycle read latency).
REQ-008 The module SHALL have port dram_q, input, 8 bits: data RAM read data (1-cycle read latency).
REQ-009 The module SHALL have port ula_out, input, 9 bits: combinational ALU result.
REQ-010 The module SHALL have port ula_sinal, input, 1 bit: combinational ALU sign flag.
REQ-011 The module SHALL have port prom_addr, output, 3 bits: program ROM address (registered).
REQ-012 The module SHALL have port dram_addr, output, 1 bit: data RAM address (registered).
REQ-013 The module SHALL have port dram_we, output, 1 bit: data RAM write enable (registered).
REQ-014 The module SHALL have port dram_wdata, output, 8 bits: data RAM write data (registered).
REQ-015 The module SHALL have port opcode, output, 4 bits: latched opcode driving the ALU.
REQ-016 The module SHALL have port result, output, 9 bits: latched ALU result.
REQ-017 The module SHALL have port result_sign, output, 1 bit: latched ALU sign.
REQ-018 The module SHALL have port result_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-019 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-020 The module SHALL have port pc, output, 3 bits: current program counter.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, FETCH, EXEC, WB; all outputs are registered.
REQ-022 In IDLE with load=1, the FSM SHALL go to LOAD, driving dram_we=1, dram_addr=0 and dram_wdata=sw_data for exactly one cycle, then return to IDLE.
REQ-023 In IDLE with step=1 and load=0, the FSM SHALL set prom_addr=pc and dram_addr=0, then go to FETCH.
REQ-024 Simultaneous load and step in IDLE SHALL perform the load only; the step is dropped, not queued.
REQ-025 FETCH SHALL be a single wait cycle covering ROM and RAM latency, then go to EXEC.
REQ-026 EXEC SHALL latch opcode<=prom_data, then go to WB; the ALU sees opcode and dram_q in WB.
REQ-027 WB SHALL latch result<=ula_out and result_sign<=ula_sinal, pulse result_valid for one cycle, and write ula_out[7:0] to dram_addr=1 with dram_we=1 for one cycle.
REQ-028 WB SHALL update PC: 0 if pc==LAST_PC, else pc+1; then go to IDLE.
REQ-029 Latency SHALL be fixed: with step sampled in cycle n, result_valid is high in cycle n+4 only.
REQ-030 step or load asserted while busy=1 SHALL be ignored with no side effect.
REQ-031 dram_we SHALL never be high in any state other than LOAD or WB.
REQ-032 Address 0 SHALL never be written except in LOAD; result[8] SHALL NOT be stored in RAM.

Reset
REQ-033 While rst=0, the module SHALL immediately force: state IDLE, pc=0, prom_addr=0, dram_addr=0, dram_we=0, dram_wdata=0, opcode=0, result=0, result_sign=0, result_valid=0, busy=0.
REQ-034 Reset asserted mid-operation SHALL abort it; no pending write or result_valid occurs after release.
REQ-035 After rst deasserts, the first step SHALL execute ROM address 0.

Verification
REQ-036 Load with sw_data=8'h35 -> one cycle of dram_we=1, dram_addr=0, dram_wdata=8'h35; busy high that one cycle.
REQ-037 Step with ROM[0]=4'h1 and ALU model returning 9'h008 -> opcode=1, result=9'h008, result_valid exactly at n+4, a write of 8'h08 to address 1, pc=1.
REQ-038 Five steps with LAST_PC=4 -> pc sequence 1,2,3,4,0; a sixth step executes ROM[0].
REQ-039 load and step in the same IDLE cycle -> load write only, no result_valid, pc unchanged.
REQ-040 step during FETCH, and rst pulsed low during EXEC -> extra step ignored; after reset all outputs are at reset values, no write or result_valid occurs, and pc=0.
